// File: rtl/data_memory_access_pkg.sv
// data_memory_access_pkg
//   Shared definitions for the MEM-stage data memory.
//   - DT_* access-size codes. The downstream sign-extension stage uses the same codes.
//   - state_t: states of the clear/ready controller.
//   - access_legal(): the alignment rule for each access size.
package data_memory_access_pkg;

  localparam logic [1:0] DT_WORD = 2'd0;
  localparam logic [1:0] DT_HALF = 2'd1;
  localparam logic [1:0] DT_BYTE = 2'd2;
  localparam logic [1:0] DT_RSVD = 2'd3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // A word access must sit on a word boundary and a halfword on a halfword
  // boundary. A byte access is always aligned. The reserved size code is
  // never legal.
  function automatic logic access_legal(input logic [1:0] datatype,
                                        input logic [1:0] lane);
    case (datatype)
      DT_WORD: return (lane == 2'b00);
      DT_HALF: return !lane[0];
      DT_BYTE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_access_if.sv
// data_memory_access_if
//   Bus between the pipeline MEM stage and the data memory.
//   master: drives the request (Address, WriteData, MemWrite, MemRead, Datatype)
//           and receives the response (ReadData, Misaligned, Busy).
//   slave : the data memory side.
interface data_memory_access_if;

  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  Datatype;
  logic [31:0] ReadData;
  logic        Misaligned;
  logic        Busy;

  modport master (
    output Address, WriteData, MemWrite, MemRead, Datatype,
    input  ReadData, Misaligned, Busy
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead, Datatype,
    output ReadData, Misaligned, Busy
  );

endinterface

// File: rtl/data_memory_lane_align.sv
// data_memory_lane_align
//   Combinational lane handling for a single access to one 32-bit word.
//   Inputs : lane (Address[1:0]), datatype, write_data, old_word (the current
//            contents of the addressed word).
//   Outputs: byte_en     - byte lanes the store would change (all zero if the
//                          access is illegal)
//            merged_word - old_word with the enabled lanes replaced by the
//                          store data
//            read_word   - the selected word, halfword or byte, right-justified
//                          and zero-extended (zero if the access is illegal)
//            misaligned  - the access violates the alignment rule
module data_memory_lane_align
  import data_memory_access_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  datatype,
  input  logic [31:0] write_data,
  input  logic [31:0] old_word,
  output logic [3:0]  byte_en,
  output logic [31:0] merged_word,
  output logic [31:0] read_word,
  output logic        misaligned
);

  logic [31:0] write_rep;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // The store data is replicated across every lane position. The enable
  // mask then picks which copies land in the word, so no shifter is needed.
  always_comb begin
    misaligned = !access_legal(datatype, lane);
    byte_en    = 4'b0000;
    write_rep  = write_data;
    read_word  = 32'h0;

    sel_half = lane[1] ? old_word[31:16] : old_word[15:0];
    case (lane)
      2'd0:    sel_byte = old_word[7:0];
      2'd1:    sel_byte = old_word[15:8];
      2'd2:    sel_byte = old_word[23:16];
      default: sel_byte = old_word[31:24];
    endcase

    case (datatype)
      DT_WORD: begin
        byte_en   = 4'b1111;
        write_rep = write_data;
        read_word = old_word;
      end
      DT_HALF: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        write_rep = {2{write_data[15:0]}};
        read_word = {16'h0, sel_half};
      end
      DT_BYTE: begin
        byte_en   = 4'b0001 << lane;
        write_rep = {4{write_data[7:0]}};
        read_word = {24'h0, sel_byte};
      end
      default: begin
        byte_en   = 4'b0000;
        write_rep = write_data;
        read_word = 32'h0;
      end
    endcase

    if (misaligned) begin
      byte_en   = 4'b0000;
      read_word = 32'h0;
    end

    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byte_en[i] ? write_rep[8*i +: 8] : old_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_memory_access.sv
// data_memory_access
//   Word-organised data memory for the MEM stage of the pipelined MIPS
//   datapath. Stores merge into the addressed byte lanes. Loads are registered
//   and lane-aligned. After every reset, a sweep clears the whole array before
//   any access is accepted.
//   Parameters: DEPTH  - number of 32-bit words (power of two)
//               ADDR_W - log2(DEPTH); the word index is Address[ADDR_W+1:2]
//   Ports     : Clk    - rising-edge clock
//               Reset  - asynchronous, active-low reset
//               bus    - data_memory_access_if.slave (request and response)
module data_memory_access
  import data_memory_access_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  data_memory_access_if.slave        bus
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clear_cnt, clear_cnt_next;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       old_word;
  logic [3:0]        byte_en;
  logic [31:0]       merged_word;
  logic [31:0]       read_word;
  logic              misaligned;
  logic              ready;
  logic              access;
  logic              store_en;

  logic [31:0]       read_data_q;
  logic              misaligned_q;

  // Address bits above the word index alias onto the array.
  logic              unused_addr_bits;

  assign idx              = bus.Address[ADDR_W+1:2];
  assign lane             = bus.Address[1:0];
  assign unused_addr_bits = ^bus.Address[31:ADDR_W+2];
  assign old_word         = mem[idx];

  data_memory_lane_align u_lane_align (
    .lane        (lane),
    .datatype    (bus.Datatype),
    .write_data  (bus.WriteData),
    .old_word    (old_word),
    .byte_en     (byte_en),
    .merged_word (merged_word),
    .read_word   (read_word),
    .misaligned  (misaligned)
  );

  assign ready    = (state == ST_READY);
  assign access   = bus.MemRead | bus.MemWrite;
  assign store_en = ready && bus.MemWrite && (byte_en != 4'b0000);

  // Controller state and clear counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_CLEAR;
      clear_cnt <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
    end
  end

  // The sweep clears word clear_cnt on each edge. The edge that clears the
  // last word also moves the controller to READY. The sweep therefore lasts
  // exactly DEPTH edges after reset is released.
  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    case (state)
      ST_CLEAR: begin
        clear_cnt_next = clear_cnt + ADDR_W'(1);
        if (clear_cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next     = ST_CLEAR;
        clear_cnt_next = '0;
      end
    endcase
  end

  // The array has no reset of its own; the sweep clears it instead. An
  // illegal store produces an all-zero byte_en and so never writes.
  always_ff @(posedge Clk) begin
    if (state == ST_CLEAR) begin
      mem[clear_cnt] <= 32'h0;
    end else if (store_en) begin
      mem[idx] <= merged_word;
    end
  end

  // read_word comes from the contents before this edge's store. A same-word
  // read and write therefore returns the old data.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      read_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
    end else if (ready) begin
      if (bus.MemRead) begin
        read_data_q <= read_word;
      end
      misaligned_q <= access && misaligned;
    end else begin
      read_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
    end
  end

  assign bus.ReadData   = read_data_q;
  assign bus.Misaligned = misaligned_q;
  assign bus.Busy       = (state == ST_CLEAR);

endmodule

// File: tb/tb_data_memory_access.sv
// tb_data_memory_access
//   Bench for data_memory_access with DEPTH=16.
//   The reference model keeps memory as a flat little-endian byte array.
//   Directed sequences are followed by randomized accesses.
module tb_data_memory_access;
  import data_memory_access_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int NBYTES = DEPTH * 4;

  logic Clk;
  logic Reset;

  data_memory_access_if bus ();

  data_memory_access #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned num_checks = 0;
  int unsigned num_fails  = 0;

  logic [7:0]  model_mem [NBYTES];
  logic [31:0] exp_rd;
  logic        exp_mis;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int unsigned accSize(input logic [1:0] dt);
    if (dt == DT_WORD) return 4;
    if (dt == DT_HALF) return 2;
    return 1;
  endfunction

  function automatic bit accIllegal(input logic [1:0] dt, input logic [31:0] addr);
    if (dt == DT_RSVD) return 1'b1;
    return (addr % accSize(dt)) != 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr, input logic [1:0] dt);
    int unsigned base;
    logic [31:0] val;
    base = addr % NBYTES;
    val  = 32'h0;
    for (int k = 0; k < int'(accSize(dt)); k++) begin
      val = val | (32'(model_mem[base + k]) << (8 * k));
    end
    return val;
  endfunction

  task automatic modelWrite(input logic [31:0] addr, input logic [1:0] dt,
                            input logic [31:0] data);
    int unsigned base;
    base = addr % NBYTES;
    for (int k = 0; k < int'(accSize(dt)); k++) begin
      model_mem[base + k] = 8'((data >> (8 * k)) & 32'hFF);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h0;
    exp_rd  = 32'h0;
    exp_mis = 1'b0;
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic we, input logic re, input logic [1:0] dt,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.MemWrite  = we;
    bus.MemRead   = re;
    bus.Datatype  = dt;
    bus.Address   = addr;
    bus.WriteData = wdata;
    @(posedge Clk);
    #1;
  endtask

  task automatic doAccess(input string tag, input logic we, input logic re,
                          input logic [1:0] dt, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bit illegal;
    illegal = accIllegal(dt, addr);
    if (re) exp_rd = illegal ? 32'h0 : modelRead(addr, dt);
    exp_mis = (we || re) && illegal;
    if (we && !illegal) modelWrite(addr, dt, wdata);
    applyStimulus(we, re, dt, addr, wdata);
    checkOutput({tag, "_rd"}, bus.ReadData, exp_rd);
    checkOutput({tag, "_mis"}, 32'(bus.Misaligned), 32'(exp_mis));
  endtask

  // Hold a read of address 0 until Busy drops. Count the edges it takes.
  task automatic waitSweep(input string tag);
    int n;
    n = 0;
    while (bus.Busy && n < 100) begin
      applyStimulus(1'b0, 1'b1, DT_WORD, 32'h0, 32'h0);
      n++;
      checkOutput({tag, "_rd_zero"}, bus.ReadData, 32'h0);
    end
    checkOutput({tag, "_len"}, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Datatype  = DT_WORD;
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    modelClear();
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("rst_rd",   bus.ReadData, 32'h0);
    checkOutput("rst_mis",  32'(bus.Misaligned), 32'h0);
    checkOutput("rst_busy", 32'(bus.Busy), 32'h1);
    @(posedge Clk);
    #1;
    Reset = 1'b1;

    // Sweep length and the first READY read
    waitSweep("sweep1");
    doAccess("first_rd", 1'b0, 1'b1, DT_WORD, 32'h0, 32'h0);
    checkOutput("first_rd_const", bus.ReadData, 32'h0);

    // Word store and load
    doAccess("sw8", 1'b1, 1'b0, DT_WORD, 32'h8, 32'hDEADBEEF);
    doAccess("lw8", 1'b0, 1'b1, DT_WORD, 32'h8, 32'h0);
    checkOutput("lw8_const", bus.ReadData, 32'hDEADBEEF);

    // Byte and halfword lane merging
    doAccess("sbC", 1'b1, 1'b0, DT_BYTE, 32'hC, 32'hFFFFFF11);
    doAccess("sbD", 1'b1, 1'b0, DT_BYTE, 32'hD, 32'hFFFFFF22);
    doAccess("shE", 1'b1, 1'b0, DT_HALF, 32'hE, 32'h1234A5F0);
    doAccess("lwC", 1'b0, 1'b1, DT_WORD, 32'hC, 32'h0);
    checkOutput("lwC_const", bus.ReadData, 32'hA5F02211);
    doAccess("lbE", 1'b0, 1'b1, DT_BYTE, 32'hE, 32'h0);
    checkOutput("lbE_const", bus.ReadData, 32'h000000F0);
    doAccess("lhE", 1'b0, 1'b1, DT_HALF, 32'hE, 32'h0);
    checkOutput("lhE_const", bus.ReadData, 32'h0000A5F0);

    // Misaligned accesses
    doAccess("sh9", 1'b1, 1'b0, DT_HALF, 32'h9, 32'h00005555);
    checkOutput("sh9_pulse", 32'(bus.Misaligned), 32'h1);
    doAccess("lw8b", 1'b0, 1'b1, DT_WORD, 32'h8, 32'h0);
    checkOutput("lw8b_const", bus.ReadData, 32'hDEADBEEF);
    checkOutput("mis_one_cycle", 32'(bus.Misaligned), 32'h0);
    doAccess("rsvd", 1'b0, 1'b1, DT_RSVD, 32'hC, 32'h0);
    checkOutput("rsvd_pulse", 32'(bus.Misaligned), 32'h1);
    checkOutput("rsvd_rd_zero", bus.ReadData, 32'h0);
    doAccess("idle", 1'b0, 1'b0, DT_WORD, 32'h0, 32'h0);

    // Same-cycle read and write to one word
    doAccess("rw8", 1'b1, 1'b1, DT_WORD, 32'h8, 32'h12345678);
    checkOutput("rw8_old", bus.ReadData, 32'hDEADBEEF);
    doAccess("lw8c", 1'b0, 1'b1, DT_WORD, 32'h8, 32'h0);
    checkOutput("lw8c_new", bus.ReadData, 32'h12345678);

    // Randomized accesses, including aliased upper address bits
    for (int i = 0; i < 400; i++) begin
      logic        we, re;
      logic [1:0]  dt;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      dt    = 2'($urandom_range(0, 3));
      addr  = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, NBYTES - 1));
      wdata = 32'($urandom);
      doAccess("rand", we, re, dt, addr, wdata);
      checkOutput("rand_busy", 32'(bus.Busy), 32'h0);
    end

    // Reset partway through a sweep
    Reset = 1'b0;
    #2;
    checkOutput("rst2_busy", 32'(bus.Busy), 32'h1);
    checkOutput("rst2_rd",   bus.ReadData, 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    modelClear();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, DT_WORD, 32'h0, 32'h0);
    checkOutput("mid_busy", 32'(bus.Busy), 32'h1);
    Reset = 1'b0;
    #2;
    checkOutput("mid_rst_busy", 32'(bus.Busy), 32'h1);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    waitSweep("sweep2");

    // Every word reads as zero after the sweep
    for (int w = 0; w < DEPTH; w++) begin
      doAccess("post_clear", 1'b0, 1'b1, DT_WORD, 32'(w * 4), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/data_memory_access.md
Name: data_memory_access

Overview:
- Word-organised data memory for the MEM stage of the pipelined MIPS datapath, with byte-lane write merging and lane-aligned registered reads.
- Its output feeds the existing size/sign-extension stage; that stage only ever sees the selected byte or halfword already right-justified and zero-extended.
- After every reset, an internal clear sweep zeroes the array before accepting any access.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- ADDR_W, 10, log2(DEPTH); the word index is Address[ADDR_W+1:2].

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the ALU.
- WriteData  input  32  store data; the low byte or halfword is used for sub-word stores.
- MemWrite  input  1  store request this cycle.
- MemRead  input  1  load request this cycle.
- Datatype  input  2  access size: 0 word, 1 halfword, 2 byte, 3 reserved.
- ReadData  output  32  registered, lane-aligned load data; drives the sign-extension stage.
- Misaligned  output  1  one-cycle registered pulse for an illegal access.
- Busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset asserted (asynchronous): ReadData=0, Misaligned=0, Busy=1, FSM=CLEAR, clear counter=0. The array is not reset directly; the sweep clears it.
- FSM CLEAR:
  - Each cycle: mem[counter]=0, counter+1.
  - When counter reaches DEPTH-1 and that word is written: go to READY and drop Busy on the next edge.
  - The sweep takes exactly DEPTH cycles after reset deassertion.
  - MemRead/MemWrite are ignored and ReadData stays 0.
- FSM READY: services accesses. No other transitions except reset.
- Reset asserted mid-sweep or mid-access: immediately return to CLEAR and restart the counter at 0. Any store in flight is lost.
- Addressing:
  - idx = Address[ADDR_W+1:2]; lane = Address[1:0]; little-endian, byte 0 = bits[7:0].
  - Address bits above ADDR_W+1 are ignored (aliasing wrap).
- Legality:
  - Word is illegal if lane != 0.
  - Halfword is illegal if lane[0] = 1.
  - Datatype 3 is always illegal.
  - Illegal access: the store is suppressed, ReadData is loaded with 0 if MemRead=1, and Misaligned=1 for the following cycle only.
  - A legal access, or no access, clears Misaligned.
- Store (MemWrite=1, legal) at the rising edge; only the addressed lanes change:
  - word: mem[idx] = WriteData.
  - half: mem[idx][16*lane[1] +: 16] = WriteData[15:0].
  - byte: mem[idx][8*lane +: 8] = WriteData[7:0].
- Load (MemRead=1, legal): one-cycle latency. ReadData is updated at the edge where MemRead is sampled:
  - word: mem[idx].
  - half: {16'h0, mem[idx][16*lane[1] +: 16]}.
  - byte: {24'h0, mem[idx][8*lane +: 8]}.
  - Sign extension is not done here.
- ReadData holds its last value when MemRead=0.
- MemRead and MemWrite both set, same word: read-before-write. ReadData returns the pre-store contents; the store still commits.

Decomposition:
- Shared package constants: DT_WORD=2'd0, DT_HALF=2'd1, DT_BYTE=2'd2, DT_RSVD=2'd3. The sign-extension stage uses the same constants.
- One natural sub-module: data_memory_lane_align, a combinational block that produces the byte-enable mask, the merged write word, the aligned read word and the misalignment flag.
- The top level keeps the FSM, the clear counter, the array and the output registers.

Test Plan (DEPTH=16):
1. Release reset, then hold MemRead=1 at Address 0x0: Busy is high for exactly 16 cycles, ReadData stays 0 throughout, and the first READY read returns 0x00000000.
2. sw 0xDEADBEEF at 0x8, then lw at 0x8: ReadData=0xDEADBEEF one cycle after the read request.
3. sb 0x11 at 0xC, sb 0x22 at 0xD, sh 0xA5F0 at 0xE, then lw at 0xC: ReadData=0xA5F02211. Then lb at 0xE gives 0x000000F0, and lh at 0xE gives 0x0000A5F0.
4. sh at 0x9: mem[2] is unchanged (lw at 0x8 still returns 0xDEADBEEF), Misaligned pulses for exactly one cycle, and lb with Datatype 3 also pulses Misaligned.
5. Same-cycle sw 0x12345678 and lw at 0x8: the ReadData produced by that edge is 0xDEADBEEF; the next lw returns 0x12345678.
6. Assert Reset after 5 cycles of the sweep: Busy stays high, the count restarts, and Busy deasserts exactly 16 cycles after reset release.
